// File: rtl/axi_lite_master_pkg.sv
// Shared constants and state encoding for the AXI4-Lite request engine.
// AXI response codes, the fixed protection value and the FSM state type.
package axi_lite_master_pkg;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    localparam logic [2:0] AxProt = 3'b000;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWaddr = 3'd1,
        StWresp = 3'd2,
        StRaddr = 3'd3,
        StRdata = 3'd4,
        StDone  = 3'd5
    } state_e;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle between the request engine (master) and a register-file slave.
// All five channels are carried; widths follow the master's parameters.
interface axi_lite_master_if #(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 32
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    logic [AddrWidth-1:0] awaddr;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;

    logic [DataWidth-1:0] wdata;
    logic [StrbWidth-1:0] wstrb;
    logic                 wvalid;
    logic                 wready;

    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    logic [AddrWidth-1:0] araddr;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;

    logic [DataWidth-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite request engine: one register command in, one response out.
// Every output is a flop, so no AXI input reaches an AXI output combinationally.
module axi_lite_master
    import axi_lite_master_pkg::*;
#(
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 32
) (
    input  logic                     aclk_i,
    input  logic                     aresetn_i,

    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic                     cmd_write_i,
    input  logic [AddrWidth-1:0]     cmd_addr_i,
    input  logic [DataWidth-1:0]     cmd_wdata_i,
    input  logic [DataWidth/8-1:0]   cmd_wstrb_i,

    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic                     rsp_write_o,
    output logic [DataWidth-1:0]     rsp_rdata_o,
    output logic [1:0]               rsp_resp_o,

    axi_lite_master_if.master        axi
);

    localparam int unsigned StrbWidth = DataWidth / 8;

    state_e               state_q, state_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 bready_q, bready_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic                 aw_done_q, aw_done_d;
    logic                 w_done_q, w_done_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [StrbWidth-1:0] wstrb_q, wstrb_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_write_q, rsp_write_d;
    logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]           rsp_resp_q, rsp_resp_d;

    logic aw_fire, w_fire;

    assign aw_fire = awvalid_q & axi.awready;
    assign w_fire  = wvalid_q & axi.wready;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr_i;
                    if (cmd_write_i) begin
                        wdata_d   = cmd_wdata_i;
                        wstrb_d   = cmd_wstrb_i;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = StWaddr;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRaddr;
                    end
                end
            end
            StWaddr: begin
                // AW and W retire independently; the response phase waits for both.
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    bready_d = 1'b1;
                    state_d  = StWresp;
                end
            end
            StWresp: begin
                if (bready_q && axi.bvalid) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = axi.bresp;
                    state_d     = StDone;
                end
            end
            StRaddr: begin
                if (arvalid_q && axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (rready_q && axi.rvalid) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = axi.rdata;
                    rsp_resp_d  = axi.rresp;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RespOkay;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_write_o = rsp_write_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_resp_o  = rsp_resp_q;

    assign axi.awaddr  = addr_q;
    assign axi.awprot  = AxProt;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = addr_q;
    assign axi.arprot  = AxProt;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: stub 6-entry register slave with tunable ready/response delays,
// a register-file reference model for expected responses, and a per-cycle protocol monitor.
module tb_axi_lite_master;
    import axi_lite_master_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int Depth = 6;

    typedef struct {
        logic          write;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    axi_lite_master_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    axi_lite_master #(.AddrWidth(AW), .DataWidth(DW)) dut (
        .aclk_i      (clk),
        .aresetn_i   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_write_i (cmd_write),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .cmd_wstrb_i (cmd_wstrb),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_write_o (rsp_write),
        .rsp_rdata_o (rsp_rdata),
        .rsp_resp_o  (rsp_resp),
        .axi         (bus)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_cmd = 0;
    int n_rsp = 0;
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem[Depth];
    logic [DW-1:0] s_mem[Depth];
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;
    logic [SW-1:0] cur_wstrb;
    logic          last_write;
    logic [DW-1:0] last_rdata;
    logic [1:0]    last_resp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    endtask

    // Stub slave: driven on the falling edge, handshakes inferred from the previous sample.
    initial begin : slave
        logic          p_aw, p_w, p_ar, p_b, p_r;
        logic [AW-1:0] p_awaddr, p_araddr, aw_a, ar_a;
        logic [DW-1:0] p_wdata, w_d;
        logic [SW-1:0] p_wstrb, w_s;
        logic          got_aw, got_w, got_ar;
        int            aw_c, w_c, ar_c, b_c, r_c, idx;
        for (int i = 0; i < Depth; i++) s_mem[i] = '0;
        {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} = '0;
        bus.bresp = '0; bus.rresp = '0; bus.rdata = '0;
        {p_aw, p_w, p_ar, p_b, p_r, got_aw, got_w, got_ar} = '0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_wstrb = '0;
        aw_a = '0; ar_a = '0; w_d = '0; w_s = '0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} = '0;
                {p_aw, p_w, p_ar, p_b, p_r, got_aw, got_w, got_ar} = '0;
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
            end else begin
                if (p_aw && bus.awready) begin got_aw = 1'b1; aw_a = p_awaddr; end
                if (p_w && bus.wready) begin got_w = 1'b1; w_d = p_wdata; w_s = p_wstrb; end
                if (p_ar && bus.arready) begin got_ar = 1'b1; ar_a = p_araddr; end
                if (p_b && bus.bvalid) bus.bvalid = 1'b0;
                if (p_r && bus.rvalid) bus.rvalid = 1'b0;
                if (got_aw && got_w && !bus.bvalid) begin
                    if (b_c >= b_dly) begin
                        idx = int'(aw_a);
                        if (idx < Depth) begin
                            for (int b = 0; b < SW; b++)
                                if (w_s[b]) s_mem[idx][8*b +: 8] = w_d[8*b +: 8];
                            bus.bresp = RespOkay;
                        end else begin
                            bus.bresp = RespSlverr;
                        end
                        bus.bvalid = 1'b1;
                        got_aw = 1'b0; got_w = 1'b0; b_c = 0;
                    end else b_c++;
                end
                if (got_ar && !bus.rvalid) begin
                    if (r_c >= r_dly) begin
                        idx = int'(ar_a);
                        bus.rdata  = (idx < Depth) ? s_mem[idx] : '0;
                        bus.rresp  = (idx < Depth) ? RespOkay : RespSlverr;
                        bus.rvalid = 1'b1;
                        got_ar = 1'b0; r_c = 0;
                    end else r_c++;
                end
                if (bus.awvalid) begin bus.awready = (aw_c >= aw_dly); aw_c++; end
                else begin bus.awready = 1'b0; aw_c = 0; end
                if (bus.wvalid) begin bus.wready = (w_c >= w_dly); w_c++; end
                else begin bus.wready = 1'b0; w_c = 0; end
                if (bus.arvalid) begin bus.arready = (ar_c >= ar_dly); ar_c++; end
                else begin bus.arready = 1'b0; ar_c = 0; end
                p_aw = bus.awvalid; p_awaddr = bus.awaddr;
                p_w  = bus.wvalid;  p_wdata  = bus.wdata; p_wstrb = bus.wstrb;
                p_ar = bus.arvalid; p_araddr = bus.araddr;
                p_b  = bus.bready;  p_r      = bus.rready;
            end
        end
    end

    // Per-cycle monitor: payload stability, channel ordering and response scoreboard.
    initial begin : monitor
        logic          pv_aw_wait, pv_w_wait, pv_ar_wait, pv_aw_hs, pv_w_hs;
        logic          pv_rsp_wait, pv_rsp_hs, aw_seen, w_seen;
        logic [AW-1:0] pv_awaddr, pv_araddr;
        logic [DW-1:0] pv_wdata;
        logic [SW-1:0] pv_wstrb;
        logic [34:0]   pv_rsp;
        rsp_t          e;
        {pv_aw_wait, pv_w_wait, pv_ar_wait, pv_aw_hs, pv_w_hs} = '0;
        {pv_rsp_wait, pv_rsp_hs, aw_seen, w_seen} = '0;
        pv_awaddr = '0; pv_araddr = '0; pv_wdata = '0; pv_wstrb = '0; pv_rsp = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                {pv_aw_wait, pv_w_wait, pv_ar_wait, pv_aw_hs, pv_w_hs} = '0;
                {pv_rsp_wait, pv_rsp_hs, aw_seen, w_seen} = '0;
            end else begin
                if (pv_aw_wait) chk("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, pv_awaddr});
                if (pv_w_wait)
                    chk("w_hold", {bus.wvalid, bus.wdata, bus.wstrb}, {1'b1, pv_wdata, pv_wstrb});
                if (pv_ar_wait) chk("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, pv_araddr});
                if (pv_aw_hs) chk("aw_drop", bus.awvalid, 1'b0);
                if (pv_w_hs) chk("w_drop", bus.wvalid, 1'b0);
                if (bus.bready) chk("bready_after_aw_w", {aw_seen, w_seen}, 2'b11);
                if (pv_rsp_wait)
                    chk("rsp_hold", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}, {1'b1, pv_rsp});
                if (pv_rsp_hs) chk("cmd_ready_after_rsp", {cmd_ready, rsp_valid}, 2'b10);
                if (rsp_valid) begin
                    chk("cmd_ready_busy", cmd_ready, 1'b0);
                    chk("rsp_expected", (exp_q.size() > 0), 1'b1);
                end
                if (bus.awvalid && bus.awready) begin
                    chk("aw_payload", {bus.awaddr, bus.awprot}, {cur_addr, 3'b000});
                    aw_seen = 1'b1;
                end
                if (bus.wvalid && bus.wready) begin
                    chk("w_payload", {bus.wdata, bus.wstrb}, {cur_wdata, cur_wstrb});
                    w_seen = 1'b1;
                end
                if (bus.arvalid && bus.arready)
                    chk("ar_payload", {bus.araddr, bus.arprot}, {cur_addr, 3'b000});
                if (bus.bvalid && bus.bready) {aw_seen, w_seen} = 2'b00;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("rsp", {rsp_write, rsp_rdata, rsp_resp}, {e.write, e.rdata, e.resp});
                    end
                    last_write = rsp_write; last_rdata = rsp_rdata; last_resp = rsp_resp;
                    n_rsp++;
                end
                pv_aw_wait  = bus.awvalid && !bus.awready;
                pv_aw_hs    = bus.awvalid && bus.awready;
                pv_awaddr   = bus.awaddr;
                pv_w_wait   = bus.wvalid && !bus.wready;
                pv_w_hs     = bus.wvalid && bus.wready;
                pv_wdata    = bus.wdata;
                pv_wstrb    = bus.wstrb;
                pv_ar_wait  = bus.arvalid && !bus.arready;
                pv_araddr   = bus.araddr;
                pv_rsp_wait = rsp_valid && !rsp_ready;
                pv_rsp_hs   = rsp_valid && rsp_ready;
                pv_rsp      = {rsp_write, rsp_rdata, rsp_resp};
            end
        end
    end

    // Offer a command and, once accepted, record what a 6-entry register file must answer.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
        rsp_t e;
        int   idx;
        logic ok;
        idx = int'(a);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        cur_addr = a; cur_wdata = d; cur_wstrb = s;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            #1;
            if (cmd_ready) begin
                ok = 1'b1;
                e.write = wr;
                if (wr) begin
                    e.rdata = '0;
                    if (idx < Depth) begin
                        for (int b = 0; b < SW; b++)
                            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                        e.resp = RespOkay;
                    end else e.resp = RespSlverr;
                end else begin
                    e.rdata = (idx < Depth) ? ref_mem[idx] : '0;
                    e.resp  = (idx < Depth) ? RespOkay : RespSlverr;
                end
                exp_q.push_back(e);
                n_cmd++;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("cmd_accept", ok, 1'b1);
    endtask

    task automatic wait_rsp();
        int i = 0;
        while (n_rsp < n_cmd && i < 100) begin
            @(negedge clk);
            i++;
        end
        #3;
        chk("rsp_arrived", (n_rsp >= n_cmd), 1'b1);
    endtask

    initial begin : main
        int i;
        int saved;
        for (int k = 0; k < Depth; k++) ref_mem[k] = '0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b1;
        cur_addr = '0; cur_wdata = '0; cur_wstrb = '0;
        last_write = 1'b0; last_rdata = '0; last_resp = '0;

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {cmd_ready, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
                         bus.rready, rsp_valid}, 7'b0);
        chk("rst_payload", {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb}, 52'h0);
        chk("rst_rsp", {rsp_rdata, rsp_resp, rsp_write}, 35'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", cmd_ready, 1'b1);

        issue(1'b1, 8'h02, 32'hDEADBEEF, 4'hF);
        wait_rsp();
        chk("write_ok", {last_write, last_rdata, last_resp}, {1'b1, 32'h0, 2'b00});
        issue(1'b0, 8'h02, 32'h0, 4'h0);
        wait_rsp();
        chk("read_back", {last_write, last_rdata, last_resp}, {1'b0, 32'hDEADBEEF, 2'b00});

        issue(1'b1, 8'h07, 32'h11223344, 4'hF);
        wait_rsp();
        chk("write_oor", {last_write, last_resp}, {1'b1, 2'b10});
        issue(1'b0, 8'h07, 32'h0, 4'h0);
        wait_rsp();
        chk("read_oor", {last_write, last_resp}, {1'b0, 2'b10});

        aw_dly = 3;
        issue(1'b1, 8'h01, 32'h12345678, 4'b0101);
        wait_rsp();
        aw_dly = 0;
        w_dly = 2;
        issue(1'b1, 8'h03, 32'hA5A5A5A5, 4'b1000);
        wait_rsp();
        w_dly = 0;
        issue(1'b0, 8'h01, 32'h0, 4'h0);
        wait_rsp();
        chk("skew_strb_read1", last_rdata, 32'h00340078);
        issue(1'b0, 8'h03, 32'h0, 4'h0);
        wait_rsp();
        chk("skew_strb_read3", last_rdata, 32'hA5000000);

        rsp_ready = 1'b0;
        issue(1'b0, 8'h02, 32'h0, 4'h0);
        i = 0;
        while (!rsp_valid && i < 50) begin @(negedge clk); i++; end
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        repeat (5) @(negedge clk);
        chk("bp_cmd_ready", cmd_ready, 1'b0);
        rsp_ready = 1'b1;
        wait_rsp();
        chk("bp_read", {last_write, last_rdata, last_resp}, {1'b0, 32'hDEADBEEF, 2'b00});

        r_dly = 20;
        issue(1'b0, 8'h02, 32'h0, 4'h0);
        i = 0;
        while (!bus.rready && i < 50) begin @(negedge clk); i++; end
        chk("mid_read_rready", bus.rready, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        n_cmd = n_rsp;
        saved = n_rsp;
        @(negedge clk);
        chk("mid_rst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                               rsp_valid, cmd_ready}, 7'b0);
        rst_n = 1'b1;
        r_dly = 0;
        @(negedge clk);
        chk("mid_rst_idle", cmd_ready, 1'b1);
        repeat (25) @(negedge clk);
        chk("aborted_no_rsp", n_rsp, saved);

        issue(1'b0, 8'h02, 32'h0, 4'h0);
        wait_rsp();
        chk("post_rst_read", {last_write, last_rdata, last_resp}, {1'b0, 32'hDEADBEEF, 2'b00});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Bus-side request engine that turns single-word register commands from local control logic into AXI4-Lite transactions toward the register-file slave. It sits directly upstream of the AXI4-Lite slave and drives all five channels. It holds exactly one transaction in flight, and returns each write status, or each read's data and status, on a response port.

## Interface
- ADDR_WIDTH, 8, AXI address width; matches the slave
- DATA_WIDTH, 32, AXI data width; multiple of 8
- ACLK  in  1  clock; everything sampled on rising edge
- ARESETn  in  1  reset, synchronous, active-low
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted when CMD_VALID & CMD_READY
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  ADDR_WIDTH  target word address
- CMD_WDATA  in  DATA_WIDTH  write data; ignored for reads
- CMD_WSTRB  in  DATA_WIDTH/8  byte strobes; ignored for reads
- RSP_VALID  out  1  result available
- RSP_READY  in  1  result consumed when RSP_VALID & RSP_READY
- RSP_WRITE  out  1  echoes the CMD_WRITE of the completed command
- RSP_RDATA  out  DATA_WIDTH  read data; 0 for writes
- RSP_RESP  out  2  BRESP or RRESP as returned by the slave
- AWADDR, AWPROT, AWVALID  out  ADDR_WIDTH, 3, 1  write address channel; AWREADY  in  1
- WDATA, WSTRB, WVALID  out  DATA_WIDTH, DATA_WIDTH/8, 1  write data channel; WREADY  in  1
- BRESP  in  2, BVALID  in  1  write response channel; BREADY  out  1
- ARADDR, ARPROT, ARVALID  out  ADDR_WIDTH, 3, 1  read address channel; ARREADY  in  1
- RDATA  in  DATA_WIDTH, RRESP  in  2, RVALID  in  1  read data channel; RREADY  out  1

## Operation
- **States:** IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- **IDLE**
  - CMD_READY=1.
  - On acceptance, latch addr/wdata/wstrb/write.
  - Go to WADDR (write) or RADDR (read).
- **WADDR**
  - AWVALID and WVALID are both asserted on entry.
  - Each is held with stable payload until its own handshake, then dropped the next cycle, independently.
  - AW and W may complete in either order or in the same cycle.
  - Once both have completed, go to WRESP.
- **WRESP**
  - BREADY=1.
  - On BVALID: capture BRESP into RSP_RESP, set RSP_RDATA=0 and RSP_WRITE=1, go to DONE.
- **RADDR**
  - ARVALID=1 until ARVALID & ARREADY, then go to RDATA.
- **RDATA**
  - RREADY=1.
  - On RVALID: capture RDATA into RSP_RDATA and RRESP into RSP_RESP, set RSP_WRITE=0, go to DONE.
- **DONE**
  - RSP_VALID=1 and RSP_* held stable until RSP_READY, then go to IDLE.
- **Protection and strobes:** AWPROT and ARPROT are constant 3'b000. WSTRB is passed through from the command unchanged.
- **Error responses:** SLVERR/DECERR are reported, not retried; the engine returns to IDLE normally.
- **Back-pressure:** CMD_READY stays 0 in every state but IDLE, so a new command cannot be accepted in the same cycle as RSP_READY.

## Timing
- **Registered outputs:** all outputs are registered. Valid/ready outputs change only on ACLK edges.
- **Reset:** ARESETn low at an edge forces state IDLE. Reset values:
  - CMD_READY=0 during reset, 1 from the first cycle after reset release.
  - AWVALID=WVALID=BREADY=ARVALID=RREADY=RSP_VALID=0.
  - AWADDR=ARADDR=0, WDATA=0, WSTRB=0.
  - RSP_RDATA=0, RSP_RESP=2'b00, RSP_WRITE=0.
- **Reset mid-transaction:** abandons the transaction with no response; the slave is reset by the same ARESETn.
- **Minimum latency with an always-ready slave that answers in the next cycle:** command accepted at edge T, AW/W or AR valid from T+1, RSP_VALID from T+4.
- **No combinational paths** from any AXI input to any AXI output.
- **Unexpected inputs:** BVALID and RVALID arriving outside WRESP/RDATA are ignored.

## Structure
- **Shared constants** (global.inc / shared package): RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, and the state encoding localparams.
- **Single module, no sub-modules.** The AW/W "done" flags are two local registers.

## Test plan
- **Write OK:** reset 3 cycles, then write addr 8'h02 data 32'hDEADBEEF strb 4'hF. Required: AWADDR=2 and WDATA=DEADBEEF held until their handshakes; RSP_VALID with RSP_RESP=00, RSP_WRITE=1, RSP_RDATA=0.
- **Read-back:** read addr 8'h02 after the write above. Required: ARADDR=2, then RSP_RDATA=32'hDEADBEEF, RSP_RESP=00, RSP_WRITE=0.
- **Out-of-range:** write to addr 8'h07 on the 6-entry slave. Required: RSP_RESP=2'b10; a following read of 8'h07 also returns RSP_RESP=2'b10.
- **Skewed AW/W:** stub slave asserts WREADY 3 cycles before AWREADY. Required: WVALID drops after its handshake; AWVALID stays high with stable AWADDR; BREADY asserts only after both handshakes.
- **Response back-pressure:** hold RSP_READY=0 for 5 cycles. Required: RSP_* stable and CMD_READY=0 throughout; CMD_READY=1 the cycle after RSP_READY is sampled high.
- **Reset mid-read:** assert ARESETn=0 while in RDATA. Required: next cycle all valids=0 and state IDLE; no RSP_VALID ever issued for the aborted read.
